dm_access_unit: RTL and testbench
=================================

Name: dm_access_unit

Overview:
- MEM-stage responder for the decoder's MemWrite and dm_ctrl outputs, plus the load-detect term of WDSel.
- Converts one load or store per request into a single word-addressed data-bus transaction with byte enables, driven over a req/ack handshake.
- Stalls the pipeline while the transaction is outstanding.
- Formats load data by lane select plus sign/zero extension, and flags misalignment and bus timeout.

Parameters:
- ADDR_W, 30: width of the bus word address, taken from byte address bits [ADDR_W+1:2].
- TIMEOUT_CYC, 16: cycles in BUS without bus_ack_i before the access aborts with an error. Must be ≥1.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- mem_read_i  in  1  load request from EX/MEM (WDSel==01)
- mem_write_i  in  1  store request (MemWrite)
- dm_ctrl_i  in  3  access size/sign: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes are treated as word
- addr_i  in  32  byte address (ALU result)
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold IF/ID/EX/MEM
- rdata_o  out  32  formatted load result
- rdata_valid_o  out  1  one-cycle pulse when rdata_o is valid
- misalign_o  out  1  one-cycle pulse: misaligned access, no bus cycle issued
- bus_err_o  out  1  one-cycle pulse: timeout abort
- bus_req_o  out  1  transaction request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  ADDR_W  word address
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated write data
- bus_ack_i  in  1  transaction complete
- bus_rdata_i  in  32  read word, valid when bus_ack_i is high

Behaviour:
- Reset, synchronous on rstn==0 at a clk edge:
  - state=IDLE, timeout counter=0.
  - All outputs 0, including bus_req_o and stall_o.
  - A reset during BUS drops bus_req_o at that edge. The transaction is abandoned and no pulse is produced.
- State IDLE:
  - If mem_read_i|mem_write_i, stall_o=1 combinationally in the same cycle.
  - Latch we=mem_write_i (write wins if both are high), dm_ctrl, addr, wdata.
  - Next state: ERR if misaligned, else BUS.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Byte accesses are never misaligned.
- State BUS:
  - bus_req_o=1 and stall_o=1.
  - bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o are registered and held stable until ack.
  - On bus_ack_i, capture formatted rdata (loads only) and go to DONE. Ack may arrive in the first BUS cycle.
  - The counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYC, go to ERR with bus_err flag, and bus_req_o drops.
  - bus_ack_i outside BUS is ignored.
- State DONE:
  - stall_o=0.
  - rdata_valid_o=1 for loads, held 0 for stores.
  - Request inputs are ignored (they still show the completed op). Next state IDLE.
- State ERR:
  - stall_o=0.
  - misalign_o or bus_err_o=1 for one cycle. rdata_o=0, rdata_valid_o=0.
  - Inputs ignored. Next state IDLE.
- Latency:
  - Request seen at cycle 0, bus_req_o at cycle 1.
  - Ack at cycle k≥1 gives DONE at k+1. Minimum 2 cycles of stall.
  - Back-to-back requests: next accept no earlier than the cycle after DONE.
- Byte enables and write data:
  - Word: be=1111, wdata as-is.
  - Half: be=0011 when addr[1]=0, 1100 when addr[1]=1; wdata={2{wdata[15:0]}}.
  - Byte: be=0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - Loads drive be=1111.
- Load format: select lane by addr[1:0], then sign- or zero-extend per dm_ctrl.
- rdata_o holds its value until the next DONE/ERR/reset.

Decomposition:
- Shared package dm_pkg holds:
  - the dm_ctrl code constants (DM_WORD, DM_HALF, DM_HALFU, DM_BYTE, DM_BYTEU), shared with the decoder;
  - the state encoding (IDLE, BUS, DONE, ERR).
- Sub-module dm_load_format: a combinational lane select plus extend block (inputs rdata word, addr[1:0], dm_ctrl; output 32-bit). The FSM, counter and store-lane logic stay in dm_access_unit.

Test Plan:
- lb, addr=0x103, bus_rdata=0x80FF_1234, ack in the first BUS cycle: be=1111, bus_addr=0x40, rdata_o=0xFFFF_FF80, rdata_valid pulses at cycle 2, stall high for cycles 0–1 only.
- sh, addr=0x22, wdata=0x0000_ABCD, ack after 3 cycles: bus_we=1, be=1100, bus_wdata=0xABCD_ABCD, all fields stable for the full BUS interval, rdata_valid stays 0.
- lw, addr=0x6: no bus_req_o, misalign_o pulses at cycle 1, stall_o is high only in cycle 0.
- lhu, addr=0x2, ack never arrives, TIMEOUT_CYC=4: bus_req_o is high for exactly 4 cycles, then bus_err_o pulses, then the unit returns to IDLE and accepts a new lbu.
- rstn=0 asserted during BUS: bus_req_o and stall_o are 0 after that edge, no pulses follow, and a stale bus_ack_i the next cycle is ignored.
- mem_read_i and mem_write_i both high, with dm_ctrl=011, addr=0x1: treated as sb with be=0010 and bus_we=1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access path: dm_ctrl access codes
// (also used by the decoder) and the access unit's state encoding.
package dm_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } dm_state_e;

  // Unknown dm_ctrl codes behave as word accesses everywhere.
  function automatic logic dm_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
    case (ctrl)
      DM_HALF, DM_HALFU: return lo[0];
      DM_BYTE, DM_BYTEU: return 1'b0;
      default:           return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_format.sv
// Load data formatting: picks the addressed byte/half lane out of the bus
// word and sign- or zero-extends it to 32 bits.
module dm_load_format
  import dm_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata_fmt
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    half_lane = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    case (addr_lo)
      2'd0:    byte_lane = rdata_word[7:0];
      2'd1:    byte_lane = rdata_word[15:8];
      2'd2:    byte_lane = rdata_word[23:16];
      default: byte_lane = rdata_word[31:24];
    endcase
  end

  always_comb begin
    case (dm_ctrl)
      DM_HALF:  rdata_fmt = {{16{half_lane[15]}}, half_lane};
      DM_HALFU: rdata_fmt = {16'h0000, half_lane};
      DM_BYTE:  rdata_fmt = {{24{byte_lane[7]}}, byte_lane};
      DM_BYTEU: rdata_fmt = {24'h000000, byte_lane};
      default:  rdata_fmt = rdata_word;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage load/store responder: turns one load or store into a single
// word-addressed bus transaction, stalling the pipeline until it completes.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        dm_ctrl_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  // Bus handshake: bus_req_o rises with all bus_* fields already valid and
  // holds them unchanged until the cycle bus_ack_i is sampled high (that cycle
  // completes the transfer) or the timeout fires; ack outside BUS is ignored.
  dm_state_e         state;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              we_q;
  logic [2:0]        ctrl_q;
  logic [1:0]        lane_q;
  logic              req;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [31:0]       load_word;

  assign req      = mem_read_i | mem_write_i;
  assign cnt_next = tmo_cnt + 1'b1;
  assign stall_o  = rstn & (((state == IDLE) & req) | (state == BUS));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata_i;
    case (dm_ctrl_i)
      DM_HALF, DM_HALFU: begin
        wdata_calc = {2{wdata_i[15:0]}};
        if (mem_write_i) be_calc = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      DM_BYTE, DM_BYTEU: begin
        wdata_calc = {4{wdata_i[7:0]}};
        if (mem_write_i) be_calc = 4'b0001 << addr_i[1:0];
      end
      default: ;
    endcase
  end

  dm_load_format u_load_format (
    .rdata_word (bus_rdata_i),
    .addr_lo    (lane_q),
    .dm_ctrl    (ctrl_q),
    .rdata_fmt  (load_word)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      we_q          <= 1'b0;
      ctrl_q        <= DM_WORD;
      lane_q        <= 2'b00;
      rdata_o       <= 32'h0;
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= '0;
      bus_be_o      <= 4'b0000;
      bus_wdata_o   <= 32'h0;
    end else begin
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= mem_write_i;
            ctrl_q  <= dm_ctrl_i;
            lane_q  <= addr_i[1:0];
            tmo_cnt <= '0;
            if (dm_misaligned(dm_ctrl_i, addr_i[1:0])) begin
              state      <= ERR;
              misalign_o <= 1'b1;
              rdata_o    <= 32'h0;
            end else begin
              state       <= BUS;
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_write_i;
              bus_addr_o  <= addr_i[ADDR_W+1:2];
              bus_be_o    <= be_calc;
              bus_wdata_o <= wdata_calc;
            end
          end
        end
        BUS: begin
          if (bus_ack_i) begin
            state     <= DONE;
            bus_req_o <= 1'b0;
            if (!we_q) begin
              rdata_o       <= load_word;
              rdata_valid_o <= 1'b1;
            end
          end else if (cnt_next == CNT_W'(TIMEOUT_CYC)) begin
            state     <= ERR;
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            rdata_o   <= 32'h0;
            tmo_cnt   <= cnt_next;
          end else begin
            tmo_cnt <= cnt_next;
          end
        end
        DONE: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
        default: begin
          state   <= IDLE;
          tmo_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed scenarios plus random loads/stores,
// checked against an arithmetic model of sizes, lanes and extension.
module tb_dm_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  dm_ctrl_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o, misalign_o, bus_err_o;
  logic        bus_req_o, bus_we_o;
  logic [29:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        rdata_known;

  dm_access_unit #(.ADDR_W(30), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .dm_ctrl_i     (dm_ctrl_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misalign_o    (misalign_o),
    .bus_err_o     (bus_err_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_be_o      (bus_be_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_ack_i     (bus_ack_i),
    .bus_rdata_i   (bus_rdata_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int size_of(input logic [2:0] ctrl);
    if (ctrl == 3'd1 || ctrl == 3'd2) return 2;
    if (ctrl == 3'd3 || ctrl == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] ctrl, input logic [31:0] addr,
                                             input logic [31:0] word);
    int sz  = size_of(ctrl);
    int off = int'(addr % 4);
    logic [31:0] mask, v;
    if (sz == 4) return word;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = (word >> (8 * off)) & mask;
    if ((ctrl == 3'd1 || ctrl == 3'd3) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] ctrl, input logic [31:0] wd);
    int sz = size_of(ctrl);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8 * i +: 8] = wd[8 * (i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] model_be(input logic wr, input logic [2:0] ctrl,
                                          input logic [31:0] addr);
    int sz = size_of(ctrl);
    if (!wr) return 4'hF;
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  // driver: one access starting from IDLE, #1 after a posedge. ack_at is the
  // BUS cycle (1-based) that sees bus_ack_i; 0 means the ack never comes.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rword, input int ack_at);
    int          sz   = size_of(ctrl);
    logic        mis  = (addr % sz) != 0;
    logic        load = !wr;
    int          n    = 0;
    logic        acked = 1'b0;
    mem_read_i  = rd;
    mem_write_i = wr;
    dm_ctrl_i   = ctrl;
    addr_i      = addr;
    wdata_i     = wd;
    bus_ack_i   = 1'b0;
    exp_q.push_back(model_load(ctrl, addr, rword));
    @(negedge clk);
    check("stall_c0", 32'(stall_o), 32'd1);
    check("req_c0", 32'(bus_req_o), 32'd0);
    @(posedge clk); #1;
    if (mis) begin
      void'(exp_q.pop_back());
      @(negedge clk);
      check("misalign", 32'(misalign_o), 32'd1);
      check("mis_stall", 32'(stall_o), 32'd0);
      check("mis_req", 32'(bus_req_o), 32'd0);
      check("mis_valid", 32'(rdata_valid_o), 32'd0);
      check("mis_rdata", rdata_o, 32'h0);
      rdata_known = 1'b1;
      exp_q.push_back(32'h0);
    end else begin
      while (n < TMO && !acked) begin
        n++;
        bus_ack_i   = (n == ack_at);
        bus_rdata_i = (n == ack_at) ? rword : $urandom;
        @(negedge clk);
        check("bus_req", 32'(bus_req_o), 32'd1);
        check("bus_stall", 32'(stall_o), 32'd1);
        check("bus_we", 32'(bus_we_o), 32'(wr));
        check("bus_addr", 32'(bus_addr_o), addr >> 2);
        check("bus_be", 32'(bus_be_o), 32'(model_be(wr, ctrl, addr)));
        if (wr) check("bus_wdata", bus_wdata_o, model_wdata(ctrl, wd));
        check("bus_valid", 32'(rdata_valid_o), 32'd0);
        acked = (n == ack_at);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
      end
      @(negedge clk);
      check("end_stall", 32'(stall_o), 32'd0);
      check("end_req", 32'(bus_req_o), 32'd0);
      if (acked) begin
        check("done_valid", 32'(rdata_valid_o), 32'(load));
        check("done_err", 32'(bus_err_o), 32'd0);
        if (load) begin
          check("done_rdata", rdata_o, exp_q[$]);
          rdata_known = 1'b1;
        end else begin
          void'(exp_q.pop_back());
          rdata_known = 1'b0;
        end
      end else begin
        void'(exp_q.pop_back());
        check("tmo_err", 32'(bus_err_o), 32'd1);
        check("tmo_valid", 32'(rdata_valid_o), 32'd0);
        check("tmo_rdata", rdata_o, 32'h0);
        rdata_known = 1'b1;
        exp_q.push_back(32'h0);
      end
    end
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_stall", 32'(stall_o), 32'd0);
    check("idle_pulses", {29'd0, rdata_valid_o, misalign_o, bus_err_o}, 32'd0);
    if (rdata_known) check("idle_hold", rdata_o, exp_q[$]);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; dm_ctrl_i = 3'd0;
    addr_i = 32'h0; wdata_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    rdata_known = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_outputs", {25'd0, stall_o, rdata_valid_o, misalign_o, bus_err_o,
                          bus_req_o, bus_we_o, 1'b0}, 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // lb, ack in first BUS cycle
    run_access(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 32'h80FF_1234, 1);
    check("lb_value", exp_q[$], 32'hFFFF_FF80);
    // sh, ack after 3 waiting cycles
    run_access(1'b0, 1'b1, 3'd1, 32'h22, 32'h0000_ABCD, 32'h0, 4);
    // lw misaligned
    run_access(1'b1, 1'b0, 3'd0, 32'h6, 32'h0, 32'h0, 1);
    // lhu timeout then lbu
    run_access(1'b1, 1'b0, 3'd2, 32'h2, 32'h0, 32'h0, 0);
    run_access(1'b1, 1'b0, 3'd4, 32'h5, 32'h0, 32'h1234_C6A5, 2);
    // both requests high: store wins
    run_access(1'b1, 1'b1, 3'd3, 32'h1, 32'h0000_00EE, 32'h0, 1);

    // reset during BUS
    mem_read_i = 1'b1; dm_ctrl_i = 3'd0; addr_i = 32'h10; bus_ack_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(bus_req_o), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_bus_req", 32'(bus_req_o), 32'd0);
    check("rst_bus_stall", 32'(stall_o), 32'd0);
    rstn = 1'b1; mem_read_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stale_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {28'd0, bus_req_o, rdata_valid_o, misalign_o, bus_err_o}, 32'd0);
      check("post_rst_rdata", rdata_o, 32'h0);
      @(posedge clk); #1;
    end
    exp_q.push_back(32'h0);
    rdata_known = 1'b1;

    // random traffic
    for (int t = 0; t < 40; t++) begin
      logic rd, wr;
      int   ack;
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      ack = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
      run_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
